ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage, directly downstream of the decode stage.
- Consumes the decoded operation, the two operands and the destination register.
- Produces the write-back triple (write enable, address, data), which goes to the EX/MEM register and back to decode for forwarding.
- Owns the HI/LO pair and a 32-iteration radix-2 divider; raises a stall request while a divide is in flight.

Parameters:
- DIV_CYCLES, 32, iterations per divide; must equal operand width.

Ports:
- clk  input  1  stage clock
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  abort in-flight instruction (exception/branch squash)
- oper_i  input  Oper_t  decoded operation
- reg1_i  input  Word_t  operand 1 (forwarded register or zero-extended immediate)
- reg2_i  input  Word_t  operand 2
- wreg_write_i  input  Bit_t  instruction writes GPR
- wreg_addr_i  input  Reg_addr_t  destination GPR
- wreg_write_o  output  Bit_t  GPR write enable to EX/MEM and decode forwarding
- wreg_addr_o  output  Reg_addr_t  destination GPR
- wreg_data_o  output  Word_t  result
- stall_req_o  output  Bit_t  hold PC, IF/ID and ID/EX

Behaviour:
- Reset:
  - State goes to IDLE; HI and LO go to 0.
  - All outputs are 0; wreg_addr_o is REG_ZERO.
- Combinational ops, same cycle, result on wreg_data_o:
  - OP_OR, OP_AND, OP_XOR, OP_NOR.
  - OP_ADDU, OP_SUBU: 32-bit, wrap-around, no overflow trap.
  - OP_SLT (signed), OP_SLTU (unsigned): result 1 or 0.
  - OP_SLL, OP_SRL, OP_SRA: shift amount is reg1_i[4:0]; reg2_i is shifted.
  - OP_LUI: {reg2_i[15:0], 16'h0}.
  - OP_MFHI / OP_MFLO: HI / LO register value.
  - OP_MTHI / OP_MTLO: HI / LO updated at the clock edge; wreg_write_o = 0.
  - OP_NOP and unknown opers: data 0, wreg_write_o = 0.
- wreg_write_o / wreg_addr_o pass through wreg_write_i / wreg_addr_i for all ops except DIV, DIVU, MTHI, MTLO and NOP, which force write enable 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE with oper_i in {OP_DIV, OP_DIVU}:
    - If reg2_i == 0, go to DONE next cycle.
    - Otherwise latch |dividend|, |divisor| (signed op) or the raw values (unsigned op) and the sign flags; counter = 0; go to BUSY.
    - stall_req_o = 1 combinationally in this cycle.
  - BUSY: one restoring shift-subtract step per cycle; counter increments; after DIV_CYCLES steps go to DONE; stall_req_o = 1.
  - DONE:
    - HI/LO written at the exiting edge: LO = quotient, HI = remainder.
    - Signed fix-up: quotient negated if the operand signs differ; remainder takes the dividend's sign.
    - stall_req_o = 0; next state IDLE.
    - Upstream has held the same DIV in ID/EX, so IDLE must not restart it: DONE sets a one-shot accepted flag, cleared when oper_i changes or a bubble arrives.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = dividend; total stall 1 cycle.
  - Latency for a nonzero divisor: stall_req_o high for exactly DIV_CYCLES+1 cycles (accept cycle plus BUSY); HI/LO visible to MFHI/MFLO from the cycle after DONE.
- Signed corner: 0x8000_0000 / 0xFFFF_FFFF gives LO = 0x8000_0000, HI = 0 (wraps, no trap).
- Inputs are stable while stall_req_o is high; upstream guarantees this. The block only samples operands at acceptance.
- flush_i:
  - In BUSY or DONE: return to IDLE next cycle, HI/LO unchanged, stall_req_o drops the same cycle.
  - Also forces this cycle's wreg_write_o to 0.
- A reset asserted mid-divide aborts it immediately; HI/LO are cleared.
- Decode forwarding relies on wreg_write_o and wreg_data_o being purely combinational for non-divide ops. They must not be registered.

Decomposition:
- cpu_defines package: Oper_t (add OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_NOR, OP_LUI), Word_t, Reg_addr_t, Bit_t, Div_state_t enum {DIV_IDLE, DIV_BUSY, DIV_DONE}.
- One sub-module, ex_div, owns the FSM, iteration datapath and sign fix-up. Handshake: start, signed_op, dividend, divisor, abort; returns busy, done, quotient, remainder.
- ex_stage keeps the ALU mux, HI/LO and the stall logic.

Test Plan:
- Reset, then OP_ADDU with 0x7FFF_FFFF and 1 -> wreg_data_o = 0x8000_0000 in the same cycle; wreg_write_o follows wreg_write_i.
- OP_DIVU 100 / 7 held until stall drops -> stall_req_o high 33 cycles; then MFLO = 14, MFHI = 2.
- OP_DIV -7 / 2 -> LO = 0xFFFF_FFFD (-3), HI = 0xFFFF_FFFF (-1); wreg_write_o = 0 throughout.
- OP_DIV with reg2_i = 0 and reg1_i = 0x1234 -> 1-cycle stall; LO = 0xFFFF_FFFF, HI = 0x1234.
- OP_DIVU started, flush_i pulsed at BUSY cycle 10 -> stall_req_o low that cycle, state IDLE, HI/LO unchanged; rst_n pulsed mid-divide -> HI = LO = 0, stall_req_o = 0.
- MTHI 0xDEAD_BEEF, then MFHI -> wreg_data_o = 0xDEAD_BEEF; OP_SRA by 4 on 0x8000_0000 -> 0xF800_0000.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: operation codes, datapath words and divider states.
package ex_stage_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [4:0]  Reg_addr_t;
  typedef logic        Bit_t;

  localparam Reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_OR   = 5'd1,
    OP_AND  = 5'd2,
    OP_XOR  = 5'd3,
    OP_NOR  = 5'd4,
    OP_ADDU = 5'd5,
    OP_SUBU = 5'd6,
    OP_SLT  = 5'd7,
    OP_SLTU = 5'd8,
    OP_SLL  = 5'd9,
    OP_SRL  = 5'd10,
    OP_SRA  = 5'd11,
    OP_LUI  = 5'd12,
    OP_MFHI = 5'd13,
    OP_MFLO = 5'd14,
    OP_MTHI = 5'd15,
    OP_MTLO = 5'd16,
    OP_DIV  = 5'd17,
    OP_DIVU = 5'd18
  } Oper_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } Div_state_t;

  // Two's-complement magnitude when en is set, raw value otherwise.
  function automatic Word_t abs_word(input Word_t v, input Bit_t en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle: decoded operation in, write-back triple and stall request out.
interface ex_stage_if import ex_stage_pkg::*; ();

  Bit_t      flush_i;
  Oper_t     oper_i;
  Word_t     reg1_i;
  Word_t     reg2_i;
  Bit_t      wreg_write_i;
  Reg_addr_t wreg_addr_i;
  Bit_t      wreg_write_o;
  Reg_addr_t wreg_addr_o;
  Word_t     wreg_data_o;
  Bit_t      stall_req_o;

  modport master (
    output flush_i, oper_i, reg1_i, reg2_i, wreg_write_i, wreg_addr_i,
    input  wreg_write_o, wreg_addr_o, wreg_data_o, stall_req_o
  );

  modport slave (
    input  flush_i, oper_i, reg1_i, reg2_i, wreg_write_i, wreg_addr_i,
    output wreg_write_o, wreg_addr_o, wreg_data_o, stall_req_o
  );

endinterface

// File: rtl/ex_div.sv
// Restoring radix-2 divider: one shift-subtract per cycle on magnitudes, sign fix-up on exit.
module ex_div import ex_stage_pkg::*; #(
  parameter int DIV_CYCLES = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  input  Bit_t  i_start,
  input  Bit_t  i_signed,
  input  Word_t i_dividend,
  input  Word_t i_divisor,
  input  Bit_t  i_abort,
  output Bit_t  o_busy,
  output Bit_t  o_done,
  output Word_t o_quotient,
  output Word_t o_remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

  Div_state_t       r_state;
  Div_state_t       w_next;
  Word_t            r_quo;
  Word_t            r_rem;
  Word_t            r_divisor;
  Bit_t             r_neg_q;
  Bit_t             r_neg_r;
  Bit_t             r_zero;
  logic [CNT_W-1:0] r_cnt;
  logic [32:0]      w_shift;
  logic [32:0]      w_diff;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DIV_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (i_start) w_next = (i_divisor == '0) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: begin
        if (i_abort)                 w_next = DIV_IDLE;
        else if (r_cnt == LAST_STEP) w_next = DIV_DONE;
      end
      DIV_DONE: w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  // Divide by zero preloads the architectural result so DONE needs no special path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_zero    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            r_zero    <= (i_divisor == '0);
            r_neg_q   <= i_signed && (i_dividend[31] ^ i_divisor[31]);
            r_neg_r   <= i_signed && i_dividend[31];
            r_divisor <= abs_word(i_divisor, i_signed);
            r_cnt     <= '0;
            if (i_divisor == '0) begin
              r_quo <= '1;
              r_rem <= i_dividend;
            end else begin
              r_quo <= abs_word(i_dividend, i_signed);
              r_rem <= '0;
            end
          end
        end
        DIV_BUSY: begin
          if (!i_abort) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!w_diff[32]) begin
              r_rem <= w_diff[31:0];
              r_quo <= {r_quo[30:0], 1'b1};
            end else begin
              r_rem <= w_shift[31:0];
              r_quo <= {r_quo[30:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state == DIV_BUSY);
  assign o_done      = (r_state == DIV_DONE);
  assign o_quotient  = (!r_zero && r_neg_q) ? (~r_quo + 32'd1) : r_quo;
  assign o_remainder = (!r_zero && r_neg_r) ? (~r_rem + 32'd1) : r_rem;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU and write-back triple, HI/LO pair, divider stall control.
module ex_stage import ex_stage_pkg::*; #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_stage_if.slave  bus
);

  Word_t r_hi;
  Word_t r_lo;
  Bit_t  r_accepted;
  Oper_t r_acc_oper;
  Word_t w_alu;
  Bit_t  w_wen_ok;
  Bit_t  w_is_div;
  Bit_t  w_start;
  Bit_t  w_div_busy;
  Bit_t  w_div_done;
  Word_t w_quo;
  Word_t w_rem;

  assign w_is_div = (bus.oper_i == OP_DIV) || (bus.oper_i == OP_DIVU);
  assign w_start  = w_is_div && !r_accepted && !w_div_busy && !w_div_done && !bus.flush_i;

  ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start),
    .i_signed    (bus.oper_i == OP_DIV),
    .i_dividend  (bus.reg1_i),
    .i_divisor   (bus.reg2_i),
    .i_abort     (bus.flush_i),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_comb begin
    w_alu    = '0;
    w_wen_ok = 1'b1;
    case (bus.oper_i)
      OP_OR:   w_alu = bus.reg1_i | bus.reg2_i;
      OP_AND:  w_alu = bus.reg1_i & bus.reg2_i;
      OP_XOR:  w_alu = bus.reg1_i ^ bus.reg2_i;
      OP_NOR:  w_alu = ~(bus.reg1_i | bus.reg2_i);
      OP_ADDU: w_alu = bus.reg1_i + bus.reg2_i;
      OP_SUBU: w_alu = bus.reg1_i - bus.reg2_i;
      OP_SLT:  w_alu = {31'b0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
      OP_SLTU: w_alu = {31'b0, bus.reg1_i < bus.reg2_i};
      OP_SLL:  w_alu = bus.reg2_i << bus.reg1_i[4:0];
      OP_SRL:  w_alu = bus.reg2_i >> bus.reg1_i[4:0];
      OP_SRA:  w_alu = Word_t'($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
      OP_LUI:  w_alu = {bus.reg2_i[15:0], 16'h0};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_wen_ok = 1'b0;
    endcase
  end

  assign bus.wreg_write_o = bus.wreg_write_i && w_wen_ok && !bus.flush_i;
  assign bus.wreg_addr_o  = bus.wreg_addr_i;
  assign bus.wreg_data_o  = w_alu;
  assign bus.stall_req_o  = w_start || (w_div_busy && !bus.flush_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!bus.flush_i) begin
      if (w_div_done) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else if (bus.oper_i == OP_MTHI) begin
        r_hi <= bus.reg1_i;
      end else if (bus.oper_i == OP_MTLO) begin
        r_lo <= bus.reg1_i;
      end
    end
  end

  // The finished DIV is still sitting in ID/EX; block a restart until a different op or bubble arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accepted <= 1'b0;
      r_acc_oper <= OP_NOP;
    end else if (w_div_done && !bus.flush_i) begin
      r_accepted <= 1'b1;
      r_acc_oper <= bus.oper_i;
    end else if ((bus.oper_i != r_acc_oper) || (bus.oper_i == OP_NOP)) begin
      r_accepted <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expectations, a negedge monitor compares.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic      cD;
    Word_t     d;
    logic      cW;
    logic      w;
    logic      cA;
    Reg_addr_t a;
    logic      cS;
    logic      s;
  } Exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  Exp_t  expQ[$];
  string nameQ[$];

  ex_stage_if bus();

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic Exp_t expAlu(input Word_t d, input logic w, input Reg_addr_t a);
    Exp_t e;
    e = '{cD: 1'b1, d: d, cW: 1'b1, w: w, cA: 1'b1, a: a, cS: 1'b1, s: 1'b0};
    return e;
  endfunction

  function automatic Exp_t expCtl(input logic s, input Reg_addr_t a);
    Exp_t e;
    e = '{cD: 1'b0, d: '0, cW: 1'b1, w: 1'b0, cA: 1'b1, a: a, cS: 1'b1, s: s};
    return e;
  endfunction

  task automatic applyStimulus(input string nm, input Oper_t op, input Word_t a, input Word_t b,
                               input logic wr, input Reg_addr_t ad, input logic fl, input Exp_t e);
    bus.oper_i       = op;
    bus.reg1_i       = a;
    bus.reg2_i       = b;
    bus.wreg_write_i = wr;
    bus.wreg_addr_i  = ad;
    bus.flush_i      = fl;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input Exp_t e);
    if (e.cD) begin
      checks++;
      if (bus.wreg_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL %s data: got %h want %h", nm, bus.wreg_data_o, e.d);
      end
    end
    if (e.cW) begin
      checks++;
      if (bus.wreg_write_o !== e.w) begin
        errors++;
        $display("[TB] FAIL %s write: got %b want %b", nm, bus.wreg_write_o, e.w);
      end
    end
    if (e.cA) begin
      checks++;
      if (bus.wreg_addr_o !== e.a) begin
        errors++;
        $display("[TB] FAIL %s addr: got %0d want %0d", nm, bus.wreg_addr_o, e.a);
      end
    end
    if (e.cS) begin
      checks++;
      if (bus.stall_req_o !== e.s) begin
        errors++;
        $display("[TB] FAIL %s stall: got %b want %b", nm, bus.stall_req_o, e.s);
      end
    end
  endtask

  always @(negedge clk) begin
    Exp_t  e;
    string nm;
    if (expQ.size() != 0) begin
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      checkOutput(nm, e);
    end
  end

  // Holds a divide until the expected stall window closes, then presents the DONE cycle.
  task automatic runDiv(input string nm, input Oper_t op, input Word_t a, input Word_t b,
                        input int nStall);
    for (int i = 0; i < nStall; i++)
      applyStimulus({nm, "_stall"}, op, a, b, 1'b1, 5'd2, 1'b0, expCtl(1'b1, 5'd2));
    applyStimulus({nm, "_done"}, op, a, b, 1'b1, 5'd2, 1'b0, expCtl(1'b0, 5'd2));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.oper_i       = OP_NOP;
    bus.reg1_i       = '0;
    bus.reg2_i       = '0;
    bus.wreg_write_i = 1'b0;
    bus.wreg_addr_i  = REG_ZERO;
    bus.flush_i      = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("reset0", OP_NOP, '0, '0, 1'b0, REG_ZERO, 1'b0, expAlu('0, 1'b0, REG_ZERO));
    applyStimulus("reset1", OP_NOP, '0, '0, 1'b0, REG_ZERO, 1'b0, expAlu('0, 1'b0, REG_ZERO));
    rst_n = 1'b1;
    applyStimulus("rst_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd3, 1'b0, expAlu(32'h0, 1'b1, 5'd3));
    applyStimulus("rst_mflo", OP_MFLO, '0, '0, 1'b1, 5'd3, 1'b0, expAlu(32'h0, 1'b1, 5'd3));

    applyStimulus("addu_wrap", OP_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd5, 1'b0,
                  expAlu(32'h8000_0000, 1'b1, 5'd5));
    applyStimulus("addu_nowr", OP_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b0, 5'd5, 1'b0,
                  expAlu(32'h8000_0000, 1'b0, 5'd5));
    applyStimulus("or",   OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 5'd6, 1'b0, expAlu(32'hF0F0_0F0F, 1'b1, 5'd6));
    applyStimulus("and",  OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1, 5'd6, 1'b0, expAlu(32'h0F00_0F00, 1'b1, 5'd6));
    applyStimulus("xor",  OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 5'd6, 1'b0, expAlu(32'hF0F0_0F0F, 1'b1, 5'd6));
    applyStimulus("nor",  OP_NOR,  32'h0,         32'h0,         1'b1, 5'd6, 1'b0, expAlu(32'hFFFF_FFFF, 1'b1, 5'd6));
    applyStimulus("subu", OP_SUBU, 32'h0,         32'h1,         1'b1, 5'd7, 1'b0, expAlu(32'hFFFF_FFFF, 1'b1, 5'd7));
    applyStimulus("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h1,         1'b1, 5'd7, 1'b0, expAlu(32'h1, 1'b1, 5'd7));
    applyStimulus("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1,         1'b1, 5'd7, 1'b0, expAlu(32'h0, 1'b1, 5'd7));
    applyStimulus("sll",  OP_SLL,  32'h4,         32'h1,         1'b1, 5'd8, 1'b0, expAlu(32'h10, 1'b1, 5'd8));
    applyStimulus("srl",  OP_SRL,  32'h4,         32'h8000_0000, 1'b1, 5'd8, 1'b0, expAlu(32'h0800_0000, 1'b1, 5'd8));
    applyStimulus("sra",  OP_SRA,  32'h4,         32'h8000_0000, 1'b1, 5'd8, 1'b0, expAlu(32'hF800_0000, 1'b1, 5'd8));
    applyStimulus("sra_mask", OP_SRA, 32'h24,     32'h8000_0000, 1'b1, 5'd8, 1'b0, expAlu(32'hF800_0000, 1'b1, 5'd8));
    applyStimulus("lui",  OP_LUI,  32'h0,         32'h0001_ABCD, 1'b1, 5'd9, 1'b0, expAlu(32'hABCD_0000, 1'b1, 5'd9));
    applyStimulus("nop_wr", OP_NOP, 32'h5,        32'h6,         1'b1, 5'd9, 1'b0, expAlu(32'h0, 1'b0, 5'd9));
    applyStimulus("unknown", Oper_t'(5'd31), 32'h5, 32'h6,      1'b1, 5'd9, 1'b0, expAlu(32'h0, 1'b0, 5'd9));

    runDiv("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33);
    applyStimulus("divu_mflo", OP_MFLO, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'd14, 1'b1, 5'd4));
    applyStimulus("divu_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'd2, 1'b1, 5'd4));

    runDiv("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    applyStimulus("div_mflo", OP_MFLO, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'hFFFF_FFFD, 1'b1, 5'd4));
    applyStimulus("div_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'hFFFF_FFFF, 1'b1, 5'd4));

    runDiv("div_zero", OP_DIV, 32'h1234, 32'h0, 1);
    applyStimulus("div_zero_hold", OP_DIV, 32'h1234, 32'h0, 1'b1, 5'd2, 1'b0, expCtl(1'b0, 5'd2));
    applyStimulus("dz_mflo", OP_MFLO, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'hFFFF_FFFF, 1'b1, 5'd4));
    applyStimulus("dz_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'h1234, 1'b1, 5'd4));

    runDiv("div_corner", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    applyStimulus("corner_mflo", OP_MFLO, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'h8000_0000, 1'b1, 5'd4));
    applyStimulus("corner_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd4, 1'b0, expAlu(32'h0, 1'b1, 5'd4));

    applyStimulus("mthi", OP_MTHI, 32'hDEAD_BEEF, '0, 1'b1, 5'd10, 1'b0, expCtl(1'b0, 5'd10));
    applyStimulus("mtlo", OP_MTLO, 32'h0BAD_F00D, '0, 1'b1, 5'd10, 1'b0, expCtl(1'b0, 5'd10));
    applyStimulus("mfhi", OP_MFHI, '0, '0, 1'b1, 5'd11, 1'b0, expAlu(32'hDEAD_BEEF, 1'b1, 5'd11));
    applyStimulus("mflo", OP_MFLO, '0, '0, 1'b1, 5'd11, 1'b0, expAlu(32'h0BAD_F00D, 1'b1, 5'd11));
    applyStimulus("flush_addu", OP_ADDU, 32'd3, 32'd4, 1'b1, 5'd12, 1'b1, expAlu(32'd7, 1'b0, 5'd12));

    for (int i = 0; i < 10; i++)
      applyStimulus("flush_pre", OP_DIVU, 32'd1000, 32'd3, 1'b1, 5'd2, 1'b0, expCtl(1'b1, 5'd2));
    applyStimulus("flush_busy", OP_DIVU, 32'd1000, 32'd3, 1'b1, 5'd2, 1'b1, expCtl(1'b0, 5'd2));
    applyStimulus("flush_idle", OP_NOP, '0, '0, 1'b0, REG_ZERO, 1'b0, expAlu(32'h0, 1'b0, REG_ZERO));
    applyStimulus("flush_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd13, 1'b0, expAlu(32'hDEAD_BEEF, 1'b1, 5'd13));
    applyStimulus("flush_mflo", OP_MFLO, '0, '0, 1'b1, 5'd13, 1'b0, expAlu(32'h0BAD_F00D, 1'b1, 5'd13));

    for (int i = 0; i < 5; i++)
      applyStimulus("rstmid_pre", OP_DIVU, 32'd50, 32'd5, 1'b1, 5'd2, 1'b0, expCtl(1'b1, 5'd2));
    rst_n = 1'b0;
    applyStimulus("rstmid", OP_NOP, '0, '0, 1'b0, REG_ZERO, 1'b0, expAlu(32'h0, 1'b0, REG_ZERO));
    rst_n = 1'b1;
    applyStimulus("rstmid_mfhi", OP_MFHI, '0, '0, 1'b1, 5'd14, 1'b0, expAlu(32'h0, 1'b1, 5'd14));
    applyStimulus("rstmid_mflo", OP_MFLO, '0, '0, 1'b1, 5'd14, 1'b0, expAlu(32'h0, 1'b1, 5'd14));

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
